// File: rtl/spi_rdid_master.sv
// spi_rdid_master: reads the JEDEC identification of an SPI flash with the RDID opcode (SPI mode 0)
module spi_rdid_master #(
  parameter logic [7:0] CMD_RDID  = 8'h9F,
  parameter int         RESP_BITS = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 get_rdid,
  output logic                 SPICLK,
  output logic                 SPIMOSI,
  input  logic                 SPIMISO,
  output logic                 SPICS_n,
  output logic                 busy,
  output logic [RESP_BITS-1:0] rdid,
  output logic                 rdid_valid
);
  localparam int CW = $clog2(RESP_BITS);
  typedef enum logic [2:0] {IDLE, START, CMD, READ, DONE} state_t;
  state_t               state_q, state_d;
  logic [RESP_BITS-1:0] sh_q, sh_d, rdid_q, rdid_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 last_q, last_d;
  logic                 clk_en_q, mosi_q;
  // Opcode and response share one shift register: the opcode leaves from the top while the response fills from the bottom
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    rdid_d  = rdid_q;
    case (state_q)
      IDLE:    state_d = get_rdid ? START : IDLE;
      START: begin
        sh_d    = {CMD_RDID, {(RESP_BITS-8){1'b0}}};
        cnt_d   = CW'(7);
        state_d = CMD;
      end
      CMD: begin
        sh_d    = sh_q << 1;
        cnt_d   = (cnt_q == '0) ? CW'(RESP_BITS-1) : cnt_q - 1'b1;
        state_d = (cnt_q == '0) ? READ : CMD;
      end
      READ: begin
        if (last_q) begin
          state_d = DONE;
          last_d  = 1'b0;
          rdid_d  = sh_q;
        end else begin
          sh_d   = {sh_q[RESP_BITS-2:0], SPIMISO};
          cnt_d  = cnt_q - 1'b1;
          last_d = (cnt_q == '0);
        end
      end
      DONE:    state_d = get_rdid ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Rising-edge state and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      rdid_q  <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      rdid_q  <= rdid_d;
    end
  end
  // Falling-edge launch of MOSI and the clock enable keeps SPICLK glitch-free and MOSI centred on its rise
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      clk_en_q <= 1'b0;
      mosi_q   <= 1'b0;
    end else begin
      clk_en_q <= (state_q == CMD) || (state_q == READ && !last_q);
      mosi_q   <= (state_q == CMD) && sh_q[RESP_BITS-1];
    end
  end
  assign SPICLK     = clk & clk_en_q;
  assign SPIMOSI    = mosi_q;
  assign busy       = (state_q == START) || (state_q == CMD) || (state_q == READ);
  assign SPICS_n    = !busy;
  assign rdid       = rdid_q;
  assign rdid_valid = (state_q == DONE);
endmodule

// File: tb/tb_spi_rdid_master.sv
// tb_spi_rdid_master: scoreboard bench with a serial-flash model and randomized ID/request timing
module tb_spi_rdid_master;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        get_rdid = 1'b0;
  logic        SPICLK, SPIMOSI, SPICS_n, busy, rdid_valid;
  logic        SPIMISO = 1'b0;
  logic [23:0] rdid;
  spi_rdid_master dut (
    .clk(clk), .reset(reset), .get_rdid(get_rdid), .SPICLK(SPICLK), .SPIMOSI(SPIMOSI),
    .SPIMISO(SPIMISO), .SPICS_n(SPICS_n), .busy(busy), .rdid(rdid), .rdid_valid(rdid_valid)
  );
  always #10 clk = ~clk;
  // Flash model: counts SPICLK pulses per chip-select window, collects the opcode, answers RDID
  logic [23:0] flash_id = 24'h202015;
  logic [7:0]  fcmd = 8'h00;
  int          bits = 0;
  int          bad_pulses = 0;
  always @(posedge SPICLK or negedge SPICS_n) begin
    if (SPICLK) begin
      if (bits < 8) fcmd = {fcmd[6:0], SPIMOSI};
      bits = bits + 1;
    end else begin
      bits = 0;
      fcmd = 8'h00;
    end
  end
  always @(posedge SPICLK) if (SPICS_n) bad_pulses = bad_pulses + 1;
  always @(negedge SPICLK)
    SPIMISO <= (!SPICS_n && fcmd == 8'h9F && bits >= 8 && bits < 32) ? flash_id[31-bits] : 1'b0;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          free_cyc = 0;
  logic [23:0] exp_q[$];
  int          exp_at[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask
  task automatic req_pulse();
    get_rdid = 1'b1;
    @(negedge clk);
    get_rdid = 1'b0;
  endtask
  task automatic wait_valid();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rdid_valid && n < 80);
    chk("valid_seen", rdid_valid, 1);
  endtask
  initial begin
    logic [7:0] op;
    fork
      // Reference model: a request is taken when no transfer is outstanding; result 34 cycles later,
      // the next request can be taken on the cycle the result is shown
      forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
          exp_q.delete();
          exp_at.delete();
          free_cyc = 0;
        end else begin
          cyc++;
          if (get_rdid && cyc >= free_cyc) begin
            exp_q.push_back(flash_id);
            exp_at.push_back(cyc + 34);
            free_cyc = cyc + 35;
          end
        end
      end
      // Monitor: every valid pulse must match the oldest outstanding expectation
      forever begin
        @(negedge clk);
        if (!reset && rdid_valid) begin
          chk("valid_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            chk("rdid", rdid, exp_q.pop_front());
            chk("latency", cyc, exp_at.pop_front());
            chk("spiclk_pulses", bits, 32);
            chk("opcode", fcmd, 8'h9F);
          end
        end
      end
    join_none
    #50;
    chk("rst_spiclk", SPICLK, 0);
    chk("rst_mosi", SPIMOSI, 0);
    chk("rst_cs_n", SPICS_n, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rdid", rdid, 0);
    chk("rst_valid", rdid_valid, 0);
    #50;
    reset = 1'b0;
    get_rdid = 1'b1;
    #20;
    get_rdid = 1'b0;
    chk("busy_after_req", busy, 1);
    chk("cs_low_after_req", SPICS_n, 0);
    #31;
    op = 8'h9F;
    for (int k = 7; k >= 0; k--) begin
      chk("mosi_bit", SPIMOSI, op[k]);
      #20;
    end
    wait_valid();
    chk("rdid_fixed", rdid, 24'h202015);
    repeat (3) @(negedge clk);
    req_pulse();
    repeat (10) @(negedge clk);
    req_pulse();
    wait_valid();
    repeat (40) @(negedge clk);
    chk("idle_busy", busy, 0);
    req_pulse();
    repeat (20) @(negedge clk);
    #13;
    reset = 1'b1;
    #1;
    chk("midrst_spiclk", SPICLK, 0);
    chk("midrst_cs_n", SPICS_n, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_mosi", SPIMOSI, 0);
    chk("midrst_rdid", rdid, 0);
    chk("midrst_valid", rdid_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    req_pulse();
    wait_valid();
    chk("rdid_after_rst", rdid, 24'h202015);
    req_pulse();
    wait_valid();
    chk("rdid_back2back", rdid, 24'h202015);
    for (int i = 0; i < 16; i++) begin
      int gap;
      flash_id = 24'($urandom);
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
      req_pulse();
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 28)) @(negedge clk);
        req_pulse();
      end
      wait_valid();
    end
    repeat (50) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    chk("pulses_cs_high", bad_pulses, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spi_rdid_master.md
Name: spi_rdid_master

Overview:
- SPI master that reads the JEDEC identification of an M25P16-class serial flash.
- On a one-cycle `get_rdid` request it sends the RDID opcode (0x9F) MSB-first, then clocks in a 24-bit identification response and presents it with a valid pulse.
- Sits between system control logic and the flash SPI pins; `SPICLK` runs at the system clock rate while a transfer is active.

Parameters:
- CMD_RDID, 8'h9F, opcode shifted out on SPIMOSI.
- RESP_BITS, 24, number of response bits captured from SPIMISO.

Ports:
- clk  input  1  system clock; all timing is referenced to it.
- reset  input  1  asynchronous, active-high reset.
- get_rdid  input  1  start request; sampled on rising clk; a one-cycle pulse is sufficient.
- SPICLK  output  1  SPI clock, mode 0; idles low.
- SPIMOSI  output  1  serial command data to the flash.
- SPIMISO  input  1  serial response data from the flash.
- SPICS_n  output  1  flash chip select, active low.
- busy  output  1  high from request acceptance until the transfer completes.
- rdid  output  RESP_BITS  captured identification, MSB first received = bit RESP_BITS-1.
- rdid_valid  output  1  one-cycle pulse when rdid is updated.

Behaviour:
- Reset (async, any time, including mid-transfer):
  - state=IDLE; SPICLK=0, SPIMOSI=0, SPICS_n=1; busy=0, rdid=0, rdid_valid=0.
  - Shift register and counters cleared.
- SPI mode 0: MOSI changes on falling clk edges; SPICLK rises on rising clk edges, mid-bit; slave samples on SPICLK rise.
- SPICLK = clk AND clk_en. clk_en is a register updated on the falling clk edge, so SPICLK is glitch-free and pulses only while clk_en=1.
- FSM states:
  - IDLE: waiting for a request.
  - START: assert chip select.
  - CMD: shift out the opcode.
  - READ: capture the response.
  - DONE: deassert and report.
- IDLE: on the rising edge where get_rdid=1 → START; busy=1; SPICS_n=0.
- START: one cycle. At the next rising edge, load shift register with CMD_RDID and bit count 7 → CMD.
- CMD:
  - At each falling edge, SPIMOSI <= shift[7] and clk_en=1.
  - At each rising edge (SPICLK rise), shift left and decrement the count.
  - After the 8th SPICLK rise → READ, count RESP_BITS-1.
- Required timing: if get_rdid is sampled at rising edge T, SPIMOSI carries opcode bit 7 during (T+1.5, T+2.5) clk periods. Each following bit occupies exactly one clk period, valid around the rising edge.
- READ:
  - SPIMOSI=0.
  - On each rising clk edge, shift SPIMISO into the LSB of the capture register, MSB first.
  - Flash drives MISO on SPICLK falling edges.
  - After RESP_BITS rises, clear clk_en at the next falling edge → DONE.
- DONE: SPICS_n=1, rdid <= capture register, rdid_valid=1 for one cycle, busy=0 → IDLE.
- get_rdid asserted while busy=1 is ignored; no queuing.
- Total: 8 + RESP_BITS SPICLK pulses per transaction; no SPICLK pulse while SPICS_n=1.
- A request exactly on the IDLE return cycle is accepted; back-to-back transfers are allowed.

Test Plan:
- Power-up: reset=1 for 100 ns, 20 ns clk → SPICLK=0, SPIMOSI=0, SPICS_n=1, busy=0, rdid=0.
- Reset deasserts at 100 ns; get_rdid=1 for 100–120 ns → SPIMOSI sampled at 150, 170, …, 290 ns reads 1,0,0,1,1,1,1,1 (0x9F).
- Same transfer with an M25P16 model → exactly 32 SPICLK pulses, SPICS_n low throughout; rdid=24'h202015 with a single rdid_valid pulse.
- get_rdid pulsed again mid-transfer → ignored; only one rdid_valid pulse, 32 SPICLK pulses total.
- Reset asserted during READ → outputs return to reset values immediately; a subsequent get_rdid completes a correct 0x202015 read.
- Second request one cycle after rdid_valid → second identical transaction and second rdid_valid.
